alu_share_arbiter: RTL

Two-requester round-robin arbiter that time-shares a single combinational ALU in the CPU datapath. It is placed between two independent operation sources, such as the main execute stage and an auxiliary address or branch unit, and the ALU instance. Each requester uses a valid/ready request channel and a valid/ready response channel. The block screens operation codes, drives the shared ALU with the granted operands, registers the result and zero flag, and holds them until the winning requester accepts them.

---
 rtl/alu_share_arbiter_if.sv | 52 +++++
 rtl/alu_share_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU signals of the two-requester ALU arbiter.
// slave: the arbiter's view; master: the requesters plus the ALU instance.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_oprd1;
  logic [WIDTH-1:0] req0_oprd2;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_oprd1;
  logic [WIDTH-1:0] req1_oprd2;
  logic [OPW-1:0]   req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  logic [WIDTH-1:0] alu_oprd1;
  logic [WIDTH-1:0] alu_oprd2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_oprd1, req0_oprd2, req0_op,
    input  req1_valid, req1_oprd1, req1_oprd2, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_oprd1, alu_oprd2, alu_op,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_oprd1, req0_oprd2, req0_op,
    output req1_valid, req1_oprd1, req1_oprd2, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_oprd1, alu_oprd2, alu_op,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Response 1 cycle after accept; a response held by rspN_ready low blocks all new accepts.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [OPW-1:0] OP_ADD = 4'b0010;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic             win_vld;
  logic             win_id;
  logic [OPW-1:0]   win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_legal;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1000, 4'b1100: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

  // Winner is only meaningful in IDLE; on a tie the requester not served last wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        win_vld = 1'b1;
        win_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        win_vld = 1'b1;
        win_id  = 1'b0;
      end else if (bus.req1_valid) begin
        win_vld = 1'b1;
        win_id  = 1'b1;
      end
    end
  end

  assign win_op    = win_id ? bus.req1_op    : bus.req0_op;
  assign win_a     = win_id ? bus.req1_oprd1 : bus.req0_oprd1;
  assign win_b     = win_id ? bus.req1_oprd2 : bus.req0_oprd2;
  assign win_legal = op_legal(win_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.alu_oprd1  = '0;
    bus.alu_oprd2  = '0;
    bus.alu_op     = '0;
    case (state)
      IDLE: begin
        bus.req0_ready = win_vld & ~win_id;
        bus.req1_ready = win_vld &  win_id;
        if (win_vld) begin
          bus.alu_oprd1 = win_a;
          bus.alu_oprd2 = win_b;
          // Illegal codes still get a defined ALU operation; its result is discarded.
          bus.alu_op    = win_legal ? win_op : OP_ADD;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        bus.rsp0_valid = ~grant_id;
        bus.rsp1_valid =  grant_id;
        if (grant_id ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // win_vld implies ready for the winner, so it marks the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (win_vld) begin
      last_grant <= win_id;
      grant_id   <= win_id;
      if (win_legal) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
        err_q    <= 1'b0;
      end else begin
        result_q <= '0;
        zero_q   <= 1'b0;
        err_q    <= 1'b1;
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

endmodule
